// File: rtl/gcd_engine.sv
// Subtractive GCD engine: captures two operands on start, one compare-and-subtract step per clock.
// Latency: done strobes 2 + S cycles after the start-sample cycle (S = subtraction count).
// Backpressure: start is ignored while busy; requests are never queued.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             zero_err_q, zero_err_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] iter_inc;

  // Saturating step counter: sticks at all-ones instead of wrapping.
  always_comb begin
    iter_inc = iter_q;
    if (iter_q != {CNT_W{1'b1}}) begin
      iter_inc = iter_q + 1'b1;
    end
  end

  // Next-state and datapath update; outputs are computed one cycle ahead so they leave as flops.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    gcd_d      = gcd_q;
    zero_err_d = zero_err_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = a_in;
          b_d        = b_in;
          iter_d     = '0;
          zero_err_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end
      CALC: begin
        if ((a_q == '0) && (b_q == '0)) begin
          gcd_d      = '0;
          zero_err_d = 1'b1;
          done_d     = 1'b1;
          state_d    = DONE;
        end else if (a_q == '0) begin
          gcd_d   = b_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (b_q == '0) begin
          gcd_d   = a_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (a_q == b_q) begin
          gcd_d   = a_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (a_q > b_q) begin
          // Larger operand is always the minuend, so no underflow.
          a_d    = a_q - b_q;
          iter_d = iter_inc;
        end else begin
          b_d    = b_q - a_q;
          iter_d = iter_inc;
        end
      end
      DONE: begin
        // busy stays high through this cycle so a start here is ignored.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything, dropping any in-flight run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      gcd_q      <= '0;
      zero_err_q <= 1'b0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      gcd_q      <= gcd_d;
      zero_err_q <= zero_err_d;
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign gcd_out    = gcd_q;
  assign zero_err   = zero_err_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: default instance plus a CNT_W=2 instance for saturation.
// Cycle 0 is the clock edge that samples start; outputs are sampled 1 time unit after edges.
// All comparisons go through chk; summary line reports totals.
module tb_gcd_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic       busy0, done0, zero0;
  logic [7:0] gcd0, iter0;
  logic       busy1, done1, zero1;
  logic [7:0] gcd1;
  logic [1:0] iter1;

  int n_checks = 0;
  int n_errors = 0;
  logic cur_sel = 1'b0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(8), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_in(a0), .b_in(b0),
    .busy(busy0), .done(done0), .gcd_out(gcd0), .zero_err(zero0), .iter_count(iter0)
  );

  gcd_engine #(.WIDTH(8), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .gcd_out(gcd1), .zero_err(zero1), .iter_count(iter1)
  );

  // Outputs of whichever instance is under test.
  logic        busy_s, done_s, zero_s;
  logic [7:0]  gcd_s;
  logic [31:0] iter_s;
  assign busy_s = cur_sel ? busy1 : busy0;
  assign done_s = cur_sel ? done1 : done0;
  assign zero_s = cur_sel ? zero1 : zero0;
  assign gcd_s  = cur_sel ? gcd1 : gcd0;
  assign iter_s = cur_sel ? {30'd0, iter1} : {24'd0, iter0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (sel) begin
      start1 = s; a1 = a; b1 = b;
    end else begin
      start0 = s; a0 = a; b0 = b;
    end
  endtask

  // One request: start sampled at cycle 0, wait for done, check result, latency and release.
  task automatic do_run(input logic sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] prev_g, input logic [7:0] exp_g, input int exp_i,
                        input logic exp_z, input int exp_lat, input bit disturb, input string tag);
    int cyc;
    cur_sel = sel;
    @(negedge clk);
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b);
    cyc = 1;
    chk({tag, ".busy_c1"}, {31'd0, busy_s}, 1);
    chk({tag, ".gcd_held"}, {24'd0, gcd_s}, {24'd0, prev_g});
    while (!done_s && cyc < 400) begin
      if (disturb && cyc == 2) drive(sel, 1'b1, 8'd5, 8'd3);
      else if (disturb) drive(sel, 1'b0, ~a, ~b);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, exp_lat);
    chk({tag, ".gcd"}, {24'd0, gcd_s}, {24'd0, exp_g});
    chk({tag, ".iter"}, iter_s, exp_i);
    chk({tag, ".zero_err"}, {31'd0, zero_s}, {31'd0, exp_z});
    chk({tag, ".busy_done"}, {31'd0, busy_s}, 1);
    drive(sel, 1'b0, a, b);
    @(posedge clk); #1;
    chk({tag, ".done_1cyc"}, {31'd0, done_s}, 0);
    chk({tag, ".busy_after"}, {31'd0, busy_s}, 0);
    chk({tag, ".gcd_hold_after"}, {24'd0, gcd_s}, {24'd0, exp_g});
  endtask

  initial begin
    int ndone;
    int first_done;
    int second_done;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, busy0}, 0);
    chk("rst.done", {31'd0, done0}, 0);
    chk("rst.gcd", {24'd0, gcd0}, 0);
    chk("rst.zero", {31'd0, zero0}, 0);
    chk("rst.iter", {24'd0, iter0}, 0);
    chk("rst.iter_small", {30'd0, iter1}, 0);
    rst = 1'b0;

    //      sel  a       b      prev   gcd   iter lat-zero lat   dist tag
    do_run(1'b0, 8'd12,  8'd8,  8'd0,  8'd4, 2,   1'b0,    4,    0, "g12_8");
    do_run(1'b0, 8'd255, 8'd1,  8'd4,  8'd1, 254, 1'b0,    256,  0, "g255_1");
    do_run(1'b0, 8'd0,   8'd9,  8'd1,  8'd9, 0,   1'b0,    2,    0, "g0_9");
    do_run(1'b0, 8'd0,   8'd0,  8'd9,  8'd0, 0,   1'b1,    2,    0, "g0_0");
    do_run(1'b0, 8'd7,   8'd7,  8'd0,  8'd7, 0,   1'b0,    2,    0, "g7_7");
    do_run(1'b0, 8'd9,   8'd0,  8'd7,  8'd9, 0,   1'b0,    2,    0, "g9_0");
    do_run(1'b0, 8'd48,  8'd18, 8'd9,  8'd6, 4,   1'b0,    6,    1, "g48_18_dist");
    do_run(1'b1, 8'd9,   8'd1,  8'd0,  8'd1, 3,   1'b0,    10,   0, "sat9_1");

    // Reset asserted during cycle 3 of a (48,18) run: outputs clear, no done ever appears.
    cur_sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd48, 8'd18);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'd48, 8'd18);
    ndone = 0;
    for (int c = 1; c < 3; c++) begin
      if (done0) ndone++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.busy", {31'd0, busy0}, 0);
    chk("midrst.done", {31'd0, done0}, 0);
    chk("midrst.gcd", {24'd0, gcd0}, 0);
    chk("midrst.iter", {24'd0, iter0}, 0);
    chk("midrst.zero", {31'd0, zero0}, 0);
    for (int c = 0; c < 8; c++) begin
      if (done0 || busy0) ndone++;
      @(posedge clk); #1;
    end
    chk("midrst.no_done", ndone, 0);

    // start held high with (21,14): accepted at cycle 0 and at cycle 5 (first IDLE after DONE).
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd21, 8'd14);
    @(posedge clk); #1;
    ndone = 0; first_done = -1; second_done = -1;
    for (int c = 1; c <= 9; c++) begin
      if (done0) begin
        ndone++;
        chk($sformatf("b2b.gcd_c%0d", c), {24'd0, gcd0}, 7);
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (c == 9) drive(1'b0, 1'b0, 8'd21, 8'd14);
      @(posedge clk); #1;
    end
    chk("b2b.ndone", ndone, 2);
    chk("b2b.first", first_done, 4);
    chk("b2b.second", second_done, 9);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b.idle_busy", {31'd0, busy0}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
